reg_display_scanner: RTL and testbench
======================================

# reg_display_scanner

Reads the core's register file through the debug read port (drives `reg_out_id`, consumes `reg_out_data`) and scans the selected 32-bit value as 8 hexadecimal digits onto a multiplexed, active-low 7-segment display. It sits outside the `Riscv` core, on the board top level, in place of ad-hoc display glue. Register selection is either manual, from switches, or automatic, stepping x0..x31. Captured values are frame-coherent: all 8 digits shown in one scan frame come from a single sample.

## Interface
- `SCAN_DIV`, default 1000: clock cycles per digit slot; legal range ≥ 2.
- `DWELL_FRAMES`, default 256: frames shown per register in auto mode; legal range ≥ 1.

- `clock`  in  1  single clock; all state is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `auto_mode`  in  1  1 = auto-step registers, 0 = manual.
- `sel_reg`  in  5  manual register index.
- `reg_out_id`  out  5  register index driven to the register file read port.
- `reg_out_data`  in  32  combinational read data for `reg_out_id`, valid in the same cycle.
- `cur_reg`  out  5  index of the register whose value is currently displayed.
- `an_n`  out  8  digit enables, active-low; bit i = digit i, digit 0 = least significant nibble.
- `seg_n`  out  7  segments, active-low; bit order {g,f,e,d,c,b,a}.

## Operation
- **Prescaler `pc`:** counts 0..SCAN_DIV-1, then wraps. `tick` = (`pc` == SCAN_DIV-1).
- **Digit index `idx` (3 bits):** increments on `tick`, wrapping 7→0. A frame is idx 0..7.
- **Index update (on the tick taking idx 6→7):**
  - `reg_out_id` ← `sel_reg` when `auto_mode`=0.
  - `reg_out_id` ← `auto_id` when `auto_mode`=1.
- **Capture (on the tick taking idx 7→0):**
  - `snap` ← `reg_out_data`.
  - `cur_reg` ← `reg_out_id`.
  - `reg_out_id` has therefore been stable for a full digit slot (SCAN_DIV cycles) before it is sampled.
- **Auto stepping:**
  - Frame counter `fc` counts captures, 0..DWELL_FRAMES-1.
  - On the capture where `fc` == DWELL_FRAMES-1: `fc` ← 0 and `auto_id` ← `auto_id`+1 (mod 32; 31→0).
  - `fc` and `auto_id` advance only while `auto_mode`=1; both hold while manual.
- **Mode switch:** takes effect at the next idx 6→7 tick. No reset of `fc`/`auto_id`.
- **`sel_reg` changes:** ignored except at the idx 6→7 tick. No synchronizer is required beyond this sampling; switches are quasi-static.
- **Display outputs:** registered, loaded on every `tick`, using the new idx value (idx_next):
  - `an_n` = ~(1 << idx_next).
  - `seg_n` = hex(`snap`[4·idx_next+3 : 4·idx_next]).
  - Exception: when idx_next = 0, the nibble comes from the value being captured, so digit 0 of a new frame already shows the new sample.
- **Hex encoding (seg_n, active-low):**
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Exactly one `an_n` bit is low at any time after the first tick.

## Timing
- **Reset values (asserted while `reset`=0, immediate):**
  - `pc`=0, `idx`=0, `fc`=0, `auto_id`=0, `snap`=0.
  - `reg_out_id`=0, `cur_reg`=0.
  - `an_n`=8'hFF (all digits off), `seg_n`=7'h7F (all segments off).
- **First tick:** cycle SCAN_DIV-1 after reset release. After it, `an_n`=8'hFD (idx=1) and `seg_n`=hex(0)=1000000.
- **Period:** frame = 8·SCAN_DIV cycles. Auto step period = DWELL_FRAMES·8·SCAN_DIV cycles.
- **Latency:**
  - `sel_reg` change to `reg_out_id`: at most 1 frame.
  - `reg_out_id` to `cur_reg` and displayed value: exactly SCAN_DIV cycles (idx 6→7 tick to 7→0 tick).
- **`reg_out_data` changes mid-frame** (writeback to the displayed register): not visible until the next capture. The frame never mixes old and new nibbles.
- **Reset mid-frame:** all state returns to reset values asynchronously. The scan restarts at idx=0 with displays blank until the first tick.

## Test plan
SCAN_DIV=4, DWELL_FRAMES=2 for all scenarios.

1. **Reset:** hold `reset`=0 for 3 cycles → `an_n`=FF, `seg_n`=7F, `reg_out_id`=0, `cur_reg`=0. Release → first `an_n` change to FD at cycle 4.
2. **Manual capture:** `sel_reg`=5, model returns 0x1234ABCF for id 5 → `reg_out_id`=5 at the first idx 6→7 tick (cycle 28). At the following 7→0 tick, `cur_reg`=5. Next frame shows digits 0..7 = F,C,b,A,4,3,2,1.
3. **Frame coherence:** change the model's data for id 5 to 0xFFFFFFFF while idx=3 → the remaining digits of that frame still show 0x1234ABCF nibbles. The next frame shows all F (0001110).
4. **Auto step:** `auto_mode`=1 → `cur_reg` sequence 0,0,1,1,2,2,… one value per frame. Force `auto_id`=31 → next step gives 0.
5. **Mode switch mid-frame:** `auto_mode` 1→0 at idx=2 with `sel_reg`=9 → `reg_out_id`=9 at the idx 6→7 tick of the same frame, and `fc`/`auto_id` hold.
6. **Async reset at idx=5:** pulse `reset` low for a non-clock-aligned half cycle → outputs return to reset values immediately, and the scan restarts from idx 0.

Source files
------------

// File: rtl/reg_display_scanner.sv
// reg_display_scanner
// Reads one core register via the debug read port and scans its 32-bit value
// as 8 hex digits on a multiplexed, active-low 7-segment display. Register
// selection is manual (sel_reg) or auto-stepping x0..x31. All 8 digits of a
// frame come from a single captured sample.
//
// Scan timing, one frame = 8 digit slots of SCAN_DIV cycles:
//   idx 6->7 tick : register index is chosen and driven on reg_out_id
//   idx 7->0 tick : reg_out_data is captured into r_snap, cur_reg follows
// So reg_out_id is stable for one whole slot before the data is sampled.
module reg_display_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DWELL_FRAMES = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        auto_mode,
  input  logic [4:0]  sel_reg,
  output logic [4:0]  reg_out_id,
  input  logic [31:0] reg_out_data,
  output logic [4:0]  cur_reg,
  output logic [7:0]  an_n,
  output logic [6:0]  seg_n
);

  localparam int PCW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FCW = (DWELL_FRAMES > 2) ? $clog2(DWELL_FRAMES) : 1;
  localparam logic [PCW-1:0] PC_LAST = PCW'(SCAN_DIV - 1);
  localparam logic [FCW-1:0] FC_LAST = FCW'(DWELL_FRAMES - 1);

  logic [PCW-1:0] r_pc;
  logic [2:0]     r_idx;
  logic [FCW-1:0] r_fc;
  logic [4:0]     r_auto_id;
  logic [31:0]    r_snap;
  logic [4:0]     r_reg_out_id;
  logic [4:0]     r_cur_reg;
  logic [7:0]     r_an_n;
  logic [6:0]     r_seg_n;

  logic           w_tick;
  logic [2:0]     w_idx_next;
  logic           w_sel_tick;
  logic           w_cap_tick;
  logic [3:0]     w_nibble;
  logic [6:0]     w_seg_code;

  // Active-low hex decode, segment order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Tick decode and the nibble shown in the slot being entered; digit 0 of a
  // new frame comes straight from the value being captured on this tick
  always_comb begin
    w_tick     = (r_pc == PC_LAST);
    w_idx_next = r_idx + 3'd1;
    w_sel_tick = w_tick && (r_idx == 3'd6);
    w_cap_tick = w_tick && (r_idx == 3'd7);
    if (w_idx_next == 3'd0) begin
      w_nibble = reg_out_data[3:0];
    end else begin
      w_nibble = r_snap[{w_idx_next, 2'b00} +: 4];
    end
    w_seg_code = hex_to_seg(w_nibble);
  end

  // Prescaler: one tick every SCAN_DIV cycles
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc <= '0;
    end else if (w_tick) begin
      r_pc <= '0;
    end else begin
      r_pc <= r_pc + 1'b1;
    end
  end

  // Digit slot index, wraps 7->0 to start a new frame
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idx <= 3'd0;
    end else if (w_tick) begin
      r_idx <= w_idx_next;
    end
  end

  // Register index chosen once per frame, a slot ahead of the capture
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_reg_out_id <= 5'd0;
    end else if (w_sel_tick) begin
      r_reg_out_id <= auto_mode ? r_auto_id : sel_reg;
    end
  end

  // Frame-coherent capture of the read data and its register index
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_snap    <= 32'd0;
      r_cur_reg <= 5'd0;
    end else if (w_cap_tick) begin
      r_snap    <= reg_out_data;
      r_cur_reg <= r_reg_out_id;
    end
  end

  // Auto stepping: dwell DWELL_FRAMES captures per register; frozen in manual
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fc      <= '0;
      r_auto_id <= 5'd0;
    end else if (w_cap_tick && auto_mode) begin
      if (r_fc == FC_LAST) begin
        r_fc      <= '0;
        r_auto_id <= r_auto_id + 5'd1;
      end else begin
        r_fc <= r_fc + 1'b1;
      end
    end
  end

  // Registered display drive, refreshed on every tick for the new slot
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_an_n  <= 8'hFF;
      r_seg_n <= 7'h7F;
    end else if (w_tick) begin
      r_an_n  <= ~(8'd1 << w_idx_next);
      r_seg_n <= w_seg_code;
    end
  end

  assign reg_out_id = r_reg_out_id;
  assign cur_reg    = r_cur_reg;
  assign an_n       = r_an_n;
  assign seg_n      = r_seg_n;

endmodule

// File: tb/tb_reg_display_scanner.sv
// Bench for reg_display_scanner: a tick/frame-level reference model plus a
// register-file array drives every-cycle comparisons, with directed checks
// for reset, first tick, selection latency, frame coherence and async reset.
module tb_reg_display_scanner;

  localparam int SD = 4;
  localparam int DW = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        auto_mode = 1'b0;
  logic [4:0]  sel_reg = 5'd0;
  logic [4:0]  reg_out_id;
  logic [31:0] reg_out_data;
  logic [4:0]  cur_reg;
  logic [7:0]  an_n;
  logic [6:0]  seg_n;

  logic [31:0] mem [32];

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  int          m_cyc;
  int          m_ticks;
  int          m_frames;
  int          m_auto;
  int          m_id;
  int          m_cur;
  logic [31:0] m_snap;
  logic [7:0]  m_an;
  logic [6:0]  m_seg;

  logic [6:0] hex_t [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  reg_display_scanner #(.SCAN_DIV(SD), .DWELL_FRAMES(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .auto_mode    (auto_mode),
    .sel_reg      (sel_reg),
    .reg_out_id   (reg_out_id),
    .reg_out_data (reg_out_data),
    .cur_reg      (cur_reg),
    .an_n         (an_n),
    .seg_n        (seg_n)
  );

  always #5 clock = ~clock;

  assign reg_out_data = mem[reg_out_id];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_ticks = 0; m_frames = 0; m_auto = 0; m_id = 0; m_cur = 0;
    m_snap = 32'd0; m_an = 8'hFF; m_seg = 7'h7F;
  endtask

  // Model: count cycles since reset; every SD-th cycle is a tick. The slot
  // entered decides what happens: 7 = pick register, 0 = capture.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      model_reset();
    end else begin
      m_cyc++;
      if (m_cyc % SD == 0) begin
        int k;
        m_ticks++;
        k = m_ticks % 8;
        if (k == 7) m_id = auto_mode ? m_auto : int'(sel_reg);
        if (k == 0) begin
          m_snap = mem[m_id];
          m_cur = m_id;
          if (auto_mode) begin
            m_frames++;
            if (m_frames == DW) begin
              m_frames = 0;
              m_auto = (m_auto + 1) % 32;
            end
          end
        end
        m_an = ~(8'd1 << k);
        m_seg = hex_t[(m_snap >> (4 * k)) & 32'hF];
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clock) begin
    check_eq("an_n", 32'(an_n), 32'(m_an));
    check_eq("seg_n", 32'(seg_n), 32'(m_seg));
    check_eq("reg_out_id", 32'(reg_out_id), 32'(m_id));
    check_eq("cur_reg", 32'(cur_reg), 32'(m_cur));
  end

  task automatic wait_idx(input int k);
    int n = 0;
    @(negedge clock);
    while ((m_ticks % 8) != k && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check_eq("wait_idx_timeout", 32'(n), 32'd0);
  endtask

  task automatic run_frames(input int f);
    repeat (f * 8 * SD) @(negedge clock);
  endtask

  initial begin
    int n;
    model_reset();
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[5] = 32'h1234ABCF;
    sel_reg = 5'd5;

    // 1. reset
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_an", 32'(an_n), 32'hFF);
    check_eq("rst_seg", 32'(seg_n), 32'h7F);
    check_eq("rst_id", 32'(reg_out_id), 32'd0);
    check_eq("rst_cur", 32'(cur_reg), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    n = 0;
    while (an_n == 8'hFF && n < 20) begin
      @(posedge clock); #1; n++;
    end
    check_eq("first_tick_cycle", 32'(n), 32'd4);
    check_eq("first_an", 32'(an_n), 32'hFD);
    check_eq("first_seg", 32'(seg_n), 32'b1000000);

    // 2. manual capture of x5
    while (reg_out_id != 5'd5 && n < 60) begin
      @(posedge clock); #1; n++;
    end
    check_eq("sel_cycle", 32'(n), 32'd28);
    wait_idx(0);
    check_eq("cur_reg5", 32'(cur_reg), 32'd5);
    check_eq("dig0_F", 32'(seg_n), 32'b0001110);
    wait_idx(1);
    check_eq("dig1_C", 32'(seg_n), 32'b1000110);

    // 3. frame coherence: writeback mid-frame stays invisible until capture
    wait_idx(3);
    mem[5] = 32'hFFFFFFFF;
    wait_idx(4);
    check_eq("coh_dig4", 32'(seg_n), 32'b0011001);
    wait_idx(7);
    check_eq("coh_dig7", 32'(seg_n), 32'b1111001);
    wait_idx(4);
    check_eq("newF_dig4", 32'(seg_n), 32'b0001110);

    // 4. auto stepping across the 31 -> 0 wrap
    auto_mode = 1'b1;
    run_frames(70);

    // 5. mode switch mid-frame
    wait_idx(2);
    auto_mode = 1'b0;
    sel_reg = 5'd9;
    wait_idx(7);
    check_eq("switch_id9", 32'(reg_out_id), 32'd9);
    run_frames(3);
    auto_mode = 1'b1;
    run_frames(5);

    // randomized mix of selections, modes and writebacks
    for (int f = 0; f < 40; f++) begin
      wait_idx($urandom_range(0, 7));
      sel_reg = 5'($urandom);
      if ($urandom_range(0, 3) == 0) auto_mode = ~auto_mode;
      mem[$urandom_range(0, 31)] = $urandom;
      mem[reg_out_id] = $urandom;
    end

    // 6. async reset mid-frame at idx 5
    wait_idx(5);
    #3 reset = 1'b0;
    #1;
    check_eq("arst_an", 32'(an_n), 32'hFF);
    check_eq("arst_seg", 32'(seg_n), 32'h7F);
    check_eq("arst_id", 32'(reg_out_id), 32'd0);
    check_eq("arst_cur", 32'(cur_reg), 32'd0);
    #4 reset = 1'b1;
    n = 0;
    while (an_n == 8'hFF && n < 20) begin
      @(posedge clock); #1; n++;
    end
    check_eq("arst_first_tick", 32'(n), 32'd4);
    check_eq("arst_first_an", 32'(an_n), 32'hFD);
    run_frames(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
